// File: rtl/vdac_pkg.sv
// Shared types and defaults for the video DAC transmitter.
package vdac_pkg;
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PRIME = 2'd1,
      ST_RUN   = 2'd2
   } vdac_state_t;

   localparam logic [15:0] BLANK_PIX = 16'h0000;

   localparam int DEF_H_ACTIVE   = 640;
   localparam int DEF_H_FP       = 16;
   localparam int DEF_H_SYNC     = 96;
   localparam int DEF_H_BP       = 48;
   localparam int DEF_V_ACTIVE   = 480;
   localparam int DEF_V_FP       = 10;
   localparam int DEF_V_SYNC     = 2;
   localparam int DEF_V_BP       = 33;
   localparam int DEF_FIFO_DEPTH = 16;
endpackage

// File: rtl/vdac_fifo.sv
// Synchronous pixel FIFO; read data comes straight from registered storage,
// so a word written in one cycle is only poppable from the next.
module vdac_fifo
   import vdac_pkg::*;
#(
   parameter int DEPTH = DEF_FIFO_DEPTH,
   parameter int WIDTH = 16
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               flush,
   input  logic               push,
   input  logic               pop,
   input  logic [WIDTH-1:0]   wdata,
   output logic [WIDTH-1:0]   rdata,
   output logic               full,
   output logic               empty,
   output logic [$clog2(DEPTH):0] level
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [LW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign full    = (cnt == LW'(DEPTH));
   assign empty   = (cnt == '0);
   assign level   = cnt;
   assign rdata   = mem[rd_ptr];
   assign do_push = push && !full && !flush;
   assign do_pop  = pop && !empty && !flush;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   cnt <= cnt + LW'(1);
            2'b01:   cnt <= cnt - LW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end
endmodule

// File: rtl/vdac_tx.sv
// Video DAC transmitter: pixel FIFO, raster timing and registered sync/data outputs.
// Optional underrun counter is built only when VDAC_TX_UNDERRUN_CNT_EN is defined.
module vdac_tx
   import vdac_pkg::*;
#(
   parameter int H_ACTIVE   = DEF_H_ACTIVE,
   parameter int H_FP       = DEF_H_FP,
   parameter int H_SYNC     = DEF_H_SYNC,
   parameter int H_BP       = DEF_H_BP,
   parameter int V_ACTIVE   = DEF_V_ACTIVE,
   parameter int V_FP       = DEF_V_FP,
   parameter int V_SYNC     = DEF_V_SYNC,
   parameter int V_BP       = DEF_V_BP,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic [15:0] pix_data_i,
   input  logic        pix_valid_i,
   output logic        pix_ready_o,
   output logic [15:0] vdat_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        de_o,
   output logic        frame_o,
   output logic [15:0] underrun_cnt_o
);
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW = $clog2(H_TOTAL + 1);
   localparam int VW = $clog2(V_TOTAL + 1);
   localparam int LW = $clog2(FIFO_DEPTH) + 1;

   localparam logic [HW-1:0] H_ACT_C  = HW'(H_ACTIVE);
   localparam logic [HW-1:0] H_SS_C   = HW'(H_ACTIVE + H_FP);
   localparam logic [HW-1:0] H_SE_C   = HW'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [HW-1:0] H_LAST_C = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_ACT_C  = VW'(V_ACTIVE);
   localparam logic [VW-1:0] V_SS_C   = VW'(V_ACTIVE + V_FP);
   localparam logic [VW-1:0] V_SE_C   = VW'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [VW-1:0] V_LAST_C = VW'(V_TOTAL - 1);
   localparam logic [LW-1:0] PRIME_C  = LW'(FIFO_DEPTH / 2);

   vdac_state_t   state;
   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [15:0]   fifo_rdata;
   logic          fifo_full;
   logic          fifo_empty;
   logic [LW-1:0] fifo_level;
   logic          run;
   logic          active;
   logic          pop;
   logic          push;

   // Ready also drops during reset so no word is accepted into a FIFO being cleared.
   assign pix_ready_o = en_i && !fifo_full && !rst_i;
   assign push        = pix_valid_i && pix_ready_o;
   assign run         = (state == ST_RUN) && en_i;
   assign active      = run && (h_cnt < H_ACT_C) && (v_cnt < V_ACT_C);
   assign pop         = active && !fifo_empty;

   vdac_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(16)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (!en_i),
      .push  (push),
      .pop   (pop),
      .wdata (pix_data_i),
      .rdata (fifo_rdata),
      .full  (fifo_full),
      .empty (fifo_empty),
      .level (fifo_level)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= ST_IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (!en_i) begin
         state <= ST_IDLE;
         h_cnt <= '0;
         v_cnt <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               state <= ST_PRIME;
               h_cnt <= '0;
               v_cnt <= '0;
            end
            ST_PRIME: begin
               if (fifo_level >= PRIME_C) state <= ST_RUN;
               h_cnt <= '0;
               v_cnt <= '0;
            end
            ST_RUN: begin
               if (h_cnt == H_LAST_C) begin
                  h_cnt <= '0;
                  v_cnt <= (v_cnt == V_LAST_C) ? '0 : v_cnt + VW'(1);
               end else begin
                  h_cnt <= h_cnt + HW'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
               h_cnt <= '0;
               v_cnt <= '0;
            end
         endcase
      end
   end

   // All video outputs share one register stage so they stay mutually aligned.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         vdat_o  <= BLANK_PIX;
         de_o    <= 1'b0;
         frame_o <= 1'b0;
         hsync_o <= 1'b1;
         vsync_o <= 1'b1;
      end else begin
         vdat_o  <= pop ? fifo_rdata : BLANK_PIX;
         de_o    <= active;
         frame_o <= run && (h_cnt == '0) && (v_cnt == '0);
         hsync_o <= !(run && (h_cnt >= H_SS_C) && (h_cnt < H_SE_C));
         vsync_o <= !(run && (v_cnt >= V_SS_C) && (v_cnt < V_SE_C));
      end
   end

`ifdef VDAC_TX_UNDERRUN_CNT_EN
   logic        underrun;
   logic [15:0] urun_cnt;

   assign underrun       = active && fifo_empty;
   assign underrun_cnt_o = urun_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         urun_cnt <= 16'h0000;
      end else if (underrun && (urun_cnt != 16'hFFFF)) begin
         urun_cnt <= urun_cnt + 16'd1;
      end else begin
         urun_cnt <= urun_cnt;
      end
   end
`else
   assign underrun_cnt_o = 16'h0000;
`endif
endmodule
